// File: rtl/axi_burst_checker.sv
// AXI4 write-slave sink that checks the data generator's burst pattern.
//
// Every accepted W beat is expected to carry 16-bit lanes equal to one running word that
// increments per beat. Burst geometry (AWLEN vs WLAST, AWSIZE) is checked and reported in
// BRESP. Running counters and a sticky error flag support bring-up and soak testing.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   clear, seed       sync pulse zeroing counters/flags and loading the expected word
//   S_AXI_AW*         write address channel (single outstanding burst)
//   S_AXI_W*          write data channel
//   S_AXI_B*          write response channel
//   burst_count       completed bursts (B handshakes)
//   beat_count        accepted W beats
//   data_err_count    beats with a data mismatch
//   proto_err_count   bursts with a length or size error
//   first_err_addr    AWADDR of the first burst with any error
//   err_seen          sticky error flag
module axi_burst_checker #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [15:0]             seed,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic [31:0]             burst_count,
  output logic [31:0]             beat_count,
  output logic [31:0]             data_err_count,
  output logic [31:0]             proto_err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic                    err_seen
);

  localparam int unsigned NumLanes = DATA_WIDTH / 16;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StData = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            beats_left_q;
  logic                  size_bad_q, len_bad_q, burst_bad_q;
  logic [15:0]           expected_q;
  logic [31:0]           burst_cnt_q, beat_cnt_q, data_err_q, proto_err_q;
  logic [ADDR_WIDTH-1:0] first_err_q;
  logic                  err_seen_q;

  logic aw_hs, w_hs, b_hs, last_hs;
  logic mismatch;
  logic [15:0] resync_word;
  logic len_bad_now, len_bad_burst, proto_bad, any_bad;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Ready/valid flags are registered so they read 0 while reset is held.
  assign aw_hs   = awready_q & S_AXI_AWVALID;
  assign w_hs    = wready_q & S_AXI_WVALID;
  assign b_hs    = bvalid_q & S_AXI_BREADY;
  assign last_hs = w_hs & S_AXI_WLAST;

  // Lane compare: only fully strobed lanes count. Downward scan leaves the lowest strobed
  // lane in resync_word, which is lane 0 whenever lane 0 is strobed.
  always_comb begin
    mismatch    = 1'b0;
    resync_word = 16'h0000;
    for (int i = NumLanes - 1; i >= 0; i--) begin
      if (&S_AXI_WSTRB[2*i +: 2]) begin
        resync_word = S_AXI_WDATA[16*i +: 16];
        if (S_AXI_WDATA[16*i +: 16] != expected_q) mismatch = 1'b1;
      end
    end
  end

  always_comb begin
    len_bad_now = 1'b0;
    if (w_hs) len_bad_now = S_AXI_WLAST ? (beats_left_q != 8'd0) : (beats_left_q == 8'd0);
    len_bad_burst = len_bad_q | len_bad_now;
    proto_bad     = size_bad_q | len_bad_burst;
    any_bad       = proto_bad | burst_bad_q | (w_hs & mismatch);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (aw_hs) state_d = StData;
      StData:  if (last_hs) state_d = StResp;
      StResp:  if (b_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      bid_q        <= '0;
      addr_q       <= '0;
      beats_left_q <= 8'd0;
      size_bad_q   <= 1'b0;
      len_bad_q    <= 1'b0;
      burst_bad_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_d == StIdle);
      wready_q  <= (state_d == StData);
      bvalid_q  <= (state_d == StResp);
      if (aw_hs) begin
        addr_q       <= S_AXI_AWADDR;
        beats_left_q <= S_AXI_AWLEN;
        bid_q        <= S_AXI_AWID;
        size_bad_q   <= (S_AXI_AWSIZE != 3'd6);
        len_bad_q    <= 1'b0;
        burst_bad_q  <= 1'b0;
      end
      if (w_hs) begin
        len_bad_q <= len_bad_burst;
        if (mismatch) burst_bad_q <= 1'b1;
        // Overlong burst: hold at zero until WLAST arrives.
        if (!S_AXI_WLAST && beats_left_q != 8'd0) beats_left_q <= beats_left_q - 8'd1;
      end
      if (last_hs) bresp_q <= proto_bad ? 2'b10 : 2'b00;
    end
  end

  // Counters and expected word; clear outranks any coincident beat or response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_q  <= 16'h0001;
      burst_cnt_q <= 32'd0;
      beat_cnt_q  <= 32'd0;
      data_err_q  <= 32'd0;
      proto_err_q <= 32'd0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
    end else if (clear) begin
      expected_q  <= seed;
      burst_cnt_q <= 32'd0;
      beat_cnt_q  <= 32'd0;
      data_err_q  <= 32'd0;
      proto_err_q <= 32'd0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      if (b_hs) burst_cnt_q <= sat_inc(burst_cnt_q);
      if (w_hs) begin
        beat_cnt_q <= sat_inc(beat_cnt_q);
        if (mismatch) begin
          data_err_q <= sat_inc(data_err_q);
          expected_q <= resync_word + 16'd1;
        end else begin
          expected_q <= expected_q + 16'd1;
        end
      end
      if (last_hs) begin
        if (proto_bad) proto_err_q <= sat_inc(proto_err_q);
        if (any_bad && !err_seen_q) begin
          first_err_q <= addr_q;
          err_seen_q  <= 1'b1;
        end
      end
    end
  end

  assign S_AXI_AWREADY   = awready_q;
  assign S_AXI_WREADY    = wready_q;
  assign S_AXI_BVALID    = bvalid_q;
  assign S_AXI_BRESP     = bresp_q;
  assign S_AXI_BID       = bid_q;
  assign burst_count     = burst_cnt_q;
  assign beat_count      = beat_cnt_q;
  assign data_err_count  = data_err_q;
  assign proto_err_count = proto_err_q;
  assign first_err_addr  = first_err_q;
  assign err_seen        = err_seen_q;

endmodule
